// File: rtl/fetch_queue_if.sv
// ---------------------------------------------------------------------------
// fetch_queue_if
// Bundles every signal passed between the fetch stage, the decode stage and
// the fetch queue that sits between them.
//
//   Fetch side : push, kill, F_PC, F_instr, F_BD, F_ExcCode  (into queue)
//                full                                        (out of queue)
//   Decode side: pop                                         (into queue)
//                D_valid, D_PC, D_instr, D_BD, D_ExcCode     (out of queue)
//   Control    : Req (exception request), flush (mispredict) (into queue)
//   Status     : count (occupancy)                           (out of queue)
//
// Modports:
//   master - the pipeline (fetch/decode/control) driving the queue
//   slave  - the fetch queue itself
// ---------------------------------------------------------------------------
interface fetch_queue_if #(
   parameter int DEPTH = 4,
   parameter int IW    = 32,
   parameter int PCW   = 32,
   parameter int EXCW  = 5
);

   // Control requests
   logic                    Req;
   logic                    flush;

   // Fetch-side entry
   logic                    push;
   logic                    kill;
   logic [PCW-1:0]          F_PC;
   logic [IW-1:0]           F_instr;
   logic                    F_BD;
   logic [EXCW-1:0]         F_ExcCode;

   // Decode-side consume
   logic                    pop;

   // Queue status and head entry
   logic                    full;
   logic                    D_valid;
   logic [PCW-1:0]          D_PC;
   logic [IW-1:0]           D_instr;
   logic                    D_BD;
   logic [EXCW-1:0]         D_ExcCode;
   logic [$clog2(DEPTH):0]  count;

   // The pipeline drives requests and entries and observes the queue head.
   modport master (
      output Req, flush, push, kill, F_PC, F_instr, F_BD, F_ExcCode, pop,
      input  full, D_valid, D_PC, D_instr, D_BD, D_ExcCode, count
   );

   // The queue consumes requests and entries and presents the head.
   modport slave (
      input  Req, flush, push, kill, F_PC, F_instr, F_BD, F_ExcCode, pop,
      output full, D_valid, D_PC, D_instr, D_BD, D_ExcCode, count
   );

endinterface

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
// A DEPTH-entry FIFO that sits between the fetch (F) and decode (D) stages. It
// replaces the single F/D pipeline register so that fetch can keep running
// while decode is stalled. Each entry holds a PC, an instruction, a
// branch-delay flag and a fetch exception code.
//
// Ports:
//   clk    - clock, all state changes on the rising edge
//   reset  - synchronous active-high reset
//   bus    - fetch_queue_if.slave carrying:
//              Req       exception/interrupt request, flushes the queue and
//                        redirects the idle head PC to HANDLER_PC
//              flush     control-flow flush, empties the queue
//              push      fetch presents an entry this cycle
//              kill      nullify the instruction of the pushed entry
//              F_*       fields of the pushed entry
//              pop       decode consumes the head this cycle
//              full      occupancy equals DEPTH, fetch must stall
//              D_valid   a head entry is present
//              D_*       head entry fields (D_PC holds the last known PC and
//                        the other fields are zero while empty)
//              count     occupancy
//
// Priority on each rising edge: reset > Req > flush > push/pop.
// ---------------------------------------------------------------------------
module fetch_queue #(
   parameter int              DEPTH      = 4,
   parameter int              IW         = 32,
   parameter int              PCW        = 32,
   parameter int              EXCW       = 5,
   parameter logic [PCW-1:0]  RESET_PC   = 32'h3000,
   parameter logic [PCW-1:0]  HANDLER_PC = 32'h4180
) (
   input logic              clk,
   input logic              reset,
   fetch_queue_if.slave     bus
);

   // Pointer width and count width. Count needs one extra bit so that a full
   // queue (count == DEPTH) can be told apart from an empty one while the two
   // pointers are equal in both cases.
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);
   localparam logic [CW-1:0] COUNT_ONE  = CW'(1);

   // Entry storage. Kept in separate arrays per field so that the head mux is
   // a plain read of each array at rd_ptr.
   logic [PCW-1:0]   pc_mem    [DEPTH];
   logic [IW-1:0]    instr_mem [DEPTH];
   logic             bd_mem    [DEPTH];
   logic [EXCW-1:0]  exc_mem   [DEPTH];

   // Queue bookkeeping
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic [CW-1:0]    count_q;
   logic [PCW-1:0]   last_pc;

   // Decoded per-cycle actions
   logic             is_empty;
   logic             is_full;
   logic             do_pop;
   logic             do_push;
   logic             write_en;
   logic [IW-1:0]    push_instr;
   logic [PCW-1:0]   head_pc;

   // Occupancy flags come straight from the registered count, so full is
   // glitch-free with respect to this cycle's push/pop inputs.
   always_comb begin
      is_empty = (count_q == '0);
      is_full  = (count_q == COUNT_FULL);
   end

   // A pop only means something when there is an entry to consume. A push is
   // accepted whenever there is room, or when the queue is full but the head
   // is leaving in the same cycle and frees a slot. On an empty queue a pop
   // with a push is just the push, because do_pop is already false there.
   always_comb begin
      do_pop  = bus.pop && !is_empty;
      do_push = bus.push && (!is_full || bus.pop);
   end

   // The storage write is suppressed by every higher-priority event, so a push
   // in the same cycle as reset, Req or flush leaves no trace in the array.
   always_comb begin
      write_en = do_push && !reset && !bus.Req && !bus.flush;
   end

   // Nullified entries (eret kill or an exception already raised during fetch)
   // carry a nop so decode never executes them; PC, BD and ExcCode still travel
   // through untouched so the exception logic can see them.
   always_comb begin
      push_instr = bus.F_instr;
      if (bus.kill || (bus.F_ExcCode != '0)) begin
         push_instr = '0;
      end
   end

   // The PC of the entry currently at the head. Used both to drive D_PC and to
   // remember the last consumed PC when the head is popped.
   always_comb begin
      head_pc = pc_mem[rd_ptr];
   end

   // Entry storage has no reset: a count of zero makes every slot invisible,
   // and a fresh push always writes a slot before the head can point at it.
   always_ff @(posedge clk) begin
      if (write_en) begin
         pc_mem[wr_ptr]    <= bus.F_PC;
         instr_mem[wr_ptr] <= push_instr;
         bd_mem[wr_ptr]    <= bus.F_BD;
         exc_mem[wr_ptr]   <= bus.F_ExcCode;
      end
   end

   // Pointer, occupancy and last-PC bookkeeping. Reset and Req drop every entry
   // and reload the idle PC. A flush drops every entry but keeps the last PC,
   // except that a pop in the same cycle still counts as consumed so decode's
   // view of the last PC stays consistent. Otherwise push and pop move their
   // pointers independently and the count follows the pair.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count_q <= '0;
         last_pc <= RESET_PC;
      end else if (bus.Req) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count_q <= '0;
         last_pc <= HANDLER_PC;
      end else if (bus.flush) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count_q <= '0;
         if (do_pop) begin
            last_pc <= head_pc;
         end
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr  <= rd_ptr + AW'(1);
            last_pc <= head_pc;
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + COUNT_ONE;
            2'b01:   count_q <= count_q - COUNT_ONE;
            default: count_q <= count_q;
         endcase
      end
   end

   // Head presentation. While an entry is present the head slot drives decode
   // directly, so a pushed entry shows up the cycle after it was written. While
   // empty decode sees a nop at the last known PC, which is what the exception
   // logic needs to compute an EPC for a stalled or freshly redirected stage.
   always_comb begin
      bus.D_valid   = !is_empty;
      bus.D_PC      = last_pc;
      bus.D_instr   = '0;
      bus.D_BD      = 1'b0;
      bus.D_ExcCode = '0;
      if (!is_empty) begin
         bus.D_PC      = head_pc;
         bus.D_instr   = instr_mem[rd_ptr];
         bus.D_BD      = bd_mem[rd_ptr];
         bus.D_ExcCode = exc_mem[rd_ptr];
      end
   end

   // Status outputs
   always_comb begin
      bus.full  = is_full;
      bus.count = count_q;
   end

endmodule

// File: tb/tb_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue
// Directed testbench for fetch_queue. Each stimulus is applied for exactly one
// rising edge and the outputs are sampled 1 ns after that edge, so every check
// sees the state produced by the edge just applied.
// ---------------------------------------------------------------------------
module tb_fetch_queue;

   localparam int DEPTH = 4;
   localparam int IW    = 32;
   localparam int PCW   = 32;
   localparam int EXCW  = 5;

   logic clk;
   logic reset;

   int checkCount;
   int errorCount;

   fetch_queue_if #(.DEPTH(DEPTH), .IW(IW), .PCW(PCW), .EXCW(EXCW)) bus ();

   fetch_queue #(
      .DEPTH      (DEPTH),
      .IW         (IW),
      .PCW        (PCW),
      .EXCW       (EXCW),
      .RESET_PC   (32'h3000),
      .HANDLER_PC (32'h4180)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Drives one cycle of inputs, lets one rising edge happen, then waits 1 ns
   // so the outputs reflect that edge before anything is checked.
   task automatic applyStimulus(input logic doReset, input logic req,
                                input logic flush, input logic push,
                                input logic kill, input logic [31:0] pc,
                                input logic [31:0] instr, input logic bd,
                                input logic [4:0] exc, input logic pop);
      reset         = doReset;
      bus.Req       = req;
      bus.flush     = flush;
      bus.push      = push;
      bus.kill      = kill;
      bus.F_PC      = pc;
      bus.F_instr   = instr;
      bus.F_BD      = bd;
      bus.F_ExcCode = exc;
      bus.pop       = pop;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
   endtask

   task automatic pushEntry(input logic [31:0] pc, input logic [31:0] instr,
                            input logic pop);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, pc, instr, 1'b0, 5'd0, pop);
   endtask

   task automatic popEntry();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b1);
   endtask

   initial begin
      checkCount = 0;
      errorCount = 0;

      // Reset, then idle: empty queue showing the reset PC.
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
      for (int i = 0; i < 3; i++) idle();
      checkOutput("rst_valid", 32'(bus.D_valid), 32'd0);
      checkOutput("rst_pc",    bus.D_PC,         32'h3000);
      checkOutput("rst_instr", bus.D_instr,      32'h0);
      checkOutput("rst_count", 32'(bus.count),   32'd0);
      checkOutput("rst_full",  32'(bus.full),    32'd0);

      // Pop on empty does nothing.
      popEntry();
      checkOutput("empty_pop_count", 32'(bus.count), 32'd0);
      checkOutput("empty_pop_pc",    bus.D_PC,       32'h3000);

      // Push with pop at empty: only the push lands, visible next cycle.
      pushEntry(32'h2ffc, 32'h24010000, 1'b1);
      checkOutput("empty_pp_count", 32'(bus.count),   32'd1);
      checkOutput("empty_pp_valid", 32'(bus.D_valid), 32'd1);
      checkOutput("empty_pp_pc",    bus.D_PC,         32'h2ffc);
      popEntry();
      checkOutput("empty_pp_after", bus.D_PC, 32'h2ffc);

      // Fill to DEPTH (pointers now start at 1, so the write pointer wraps).
      for (int i = 0; i < 4; i++) begin
         pushEntry(32'h3000 + 32'(4 * i), 32'h24010001 + 32'(i), 1'b0);
         checkOutput("fill_count", 32'(bus.count), 32'(i + 1));
      end
      checkOutput("fill_full",  32'(bus.full), 32'd1);
      checkOutput("fill_head",  bus.D_PC,      32'h3000);
      checkOutput("fill_instr", bus.D_instr,   32'h24010001);

      // Push while full without pop is ignored.
      pushEntry(32'h3010, 32'h24010005, 1'b0);
      checkOutput("ovf_count", 32'(bus.count), 32'd4);
      checkOutput("ovf_head",  bus.D_PC,       32'h3000);

      // Drain in order.
      for (int i = 0; i < 4; i++) begin
         checkOutput("drain_pc",    bus.D_PC,    32'h3000 + 32'(4 * i));
         checkOutput("drain_instr", bus.D_instr, 32'h24010001 + 32'(i));
         popEntry();
      end
      checkOutput("drain_valid", 32'(bus.D_valid), 32'd0);
      checkOutput("drain_pc_end", bus.D_PC,        32'h300c);
      checkOutput("drain_instr0", bus.D_instr,     32'h0);

      // Full with simultaneous push and pop: count holds, head advances.
      for (int i = 0; i < 4; i++) pushEntry(32'h3000 + 32'(4 * i), 32'h24010001 + 32'(i), 1'b0);
      pushEntry(32'h3010, 32'h24010005, 1'b1);
      checkOutput("fpp_count", 32'(bus.count), 32'd4);
      checkOutput("fpp_full",  32'(bus.full),  32'd1);
      checkOutput("fpp_head",  bus.D_PC,       32'h3004);
      for (int i = 0; i < 4; i++) begin
         checkOutput("wrap_pc", bus.D_PC, 32'h3004 + 32'(4 * i));
         popEntry();
      end
      checkOutput("wrap_count", 32'(bus.count), 32'd0);
      checkOutput("wrap_last",  bus.D_PC,       32'h3010);

      // Nullification: fetch exception and kill both turn the instr into a nop.
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h3000, 32'h24010001, 1'b0, 5'd4, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h3004, 32'h24010002, 1'b1, 5'd0, 1'b0);
      checkOutput("exc_pc",    bus.D_PC,           32'h3000);
      checkOutput("exc_instr", bus.D_instr,        32'h0);
      checkOutput("exc_code",  32'(bus.D_ExcCode), 32'd4);
      checkOutput("exc_bd",    32'(bus.D_BD),      32'd0);
      popEntry();
      checkOutput("kill_pc",    bus.D_PC,           32'h3004);
      checkOutput("kill_instr", bus.D_instr,        32'h0);
      checkOutput("kill_code",  32'(bus.D_ExcCode), 32'd0);
      checkOutput("kill_bd",    32'(bus.D_BD),      32'd1);
      popEntry();

      // Req with a same-cycle push and pop discards both.
      pushEntry(32'h3000, 32'h24010001, 1'b0);
      pushEntry(32'h3004, 32'h24010002, 1'b0);
      checkOutput("req_pre_count", 32'(bus.count), 32'd2);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h3008, 32'h24010003, 1'b0, 5'd0, 1'b1);
      checkOutput("req_count", 32'(bus.count),   32'd0);
      checkOutput("req_valid", 32'(bus.D_valid), 32'd0);
      checkOutput("req_pc",    bus.D_PC,         32'h4180);
      checkOutput("req_instr", bus.D_instr,      32'h0);
      pushEntry(32'h4180, 32'h24010005, 1'b0);
      checkOutput("hnd_valid", 32'(bus.D_valid), 32'd1);
      checkOutput("hnd_pc",    bus.D_PC,         32'h4180);
      checkOutput("hnd_instr", bus.D_instr,      32'h24010005);
      popEntry();

      // flush with pop: queue empties, last PC is the popped head.
      pushEntry(32'h3000, 32'h24010001, 1'b0);
      pushEntry(32'h3004, 32'h24010002, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h3008, 32'h24010003, 1'b0, 5'd0, 1'b1);
      checkOutput("flush_count", 32'(bus.count),   32'd0);
      checkOutput("flush_valid", 32'(bus.D_valid), 32'd0);
      checkOutput("flush_pc",    bus.D_PC,         32'h3000);

      // Req and flush together: Req wins and redirects to the handler.
      pushEntry(32'h3000, 32'h24010001, 1'b0);
      pushEntry(32'h3004, 32'h24010002, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
      checkOutput("reqfl_count", 32'(bus.count), 32'd0);
      checkOutput("reqfl_pc",    bus.D_PC,       32'h4180);

      // Reset mid-stream drops entries and restores the reset PC.
      pushEntry(32'h5000, 32'h24010007, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h5004, 32'h24010008, 1'b0, 5'd0, 1'b0);
      checkOutput("mid_rst_count", 32'(bus.count), 32'd0);
      checkOutput("mid_rst_pc",    bus.D_PC,       32'h3000);
      idle();

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised successor to the single-entry F/D pipeline register: a DEPTH-entry FIFO between the fetch (F) and decode (D) stages.
- Fetch can run ahead while decode stalls.
- Each entry carries PC, instruction, branch-delay flag and exception code.
- Supports exception-request flush to the handler PC, control-flow flush, and instruction nullification (exception/eret) per entry.

Parameters:
DEPTH, 4, number of entries; power of two, >= 2
IW, 32, instruction width
PCW, 32, PC width
EXCW, 5, exception-code width
RESET_PC, 32'h3000, D_PC presented after reset while empty
HANDLER_PC, 32'h4180, D_PC presented after Req while empty

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
Req  input  1  exception/interrupt request; flushes entire queue
flush  input  1  control-flow flush (mispredict); flushes queue, no PC override
push  input  1  F has a valid entry this cycle
kill  input  1  nullify the pushed entry's instruction (eret in D)
F_PC  input  PCW  PC of pushed entry
F_instr  input  IW  instruction of pushed entry
F_BD  input  1  pushed entry is in a delay slot
F_ExcCode  input  EXCW  fetch exception of pushed entry (0 = none)
pop  input  1  D consumes head this cycle (D not stalled)
full  output  1  count == DEPTH; F must stall
D_valid  output  1  head entry present
D_PC  output  PCW  head PC, or last-known PC when empty
D_instr  output  IW  head instruction, 0 (nop) when empty
D_BD  output  1  head BD, 0 when empty
D_ExcCode  output  EXCW  head ExcCode, 0 when empty
count  output  $clog2(DEPTH)+1  occupancy

Behaviour:
- Synchronous reset:
  - rd_ptr = wr_ptr = 0; count = 0.
  - last_pc = RESET_PC.
  - Outputs: D_valid=0, D_PC=RESET_PC, D_instr=0, D_BD=0, D_ExcCode=0, full=0.
- Priority per rising edge: reset > Req > flush > push/pop.
- Req:
  - Pointers and count cleared; last_pc = HANDLER_PC.
  - Any same-cycle push/pop is discarded.
  - Next cycle: D_valid=0, D_PC=HANDLER_PC, D_instr=0.
- flush:
  - Pointers and count cleared; last_pc unchanged except as below.
  - Same-cycle push discarded.
  - A same-cycle pop still updates last_pc to the popped PC.
- Push (accepted when push=1 and (not full, or pop=1)):
  - Writes entry at wr_ptr; wr_ptr increments mod DEPTH.
  - Stored instr = 0 if kill=1 or F_ExcCode != 0; else F_instr.
  - PC, BD and ExcCode are stored unmodified.
- Push ignored when full and pop=0; no overwrite, count unchanged.
- Pop (effective only when count > 0): rd_ptr increments mod DEPTH; last_pc = popped PC.
- Pop on empty is a no-op.
- Simultaneous push and pop:
  - Count unchanged; legal at full and at every non-empty level.
  - At empty, only the push takes effect: entry visible on D next cycle, count becomes 1.
- Head outputs:
  - Combinational from storage at rd_ptr when count > 0.
  - When empty, D_PC = last_pc and the other fields are 0.
  - Latency push -> D visible: 1 cycle.
- full = (count == DEPTH), combinational from registered count.
- Pointer wrap: both pointers are $clog2(DEPTH) bits and wrap naturally; count disambiguates full vs empty.
- Reset or Req mid-stream: all entries dropped regardless of contents; storage need not be cleared.

Test Plan:
- Reset then idle 3 cycles -> D_valid=0, D_PC=32'h3000, D_instr=0, count=0, full=0.
- Push PCs 3000/3004/3008/300C (instr 0x24010001..4) with pop=0 -> count=4, full=1; 5th push of 3010 ignored; pop x4 returns 3000..300C in order; then empty with D_PC=300C.
- Full queue, push 3010 with pop=1 same cycle -> count stays 4, head becomes 3004; later pops yield 3004, 3008, 300C, 3010 (pointer wrap).
- Push 3000 with F_ExcCode=4 and push 3004 with kill=1 -> D_instr=0 for both; D_ExcCode=4 then 0; PCs preserved.
- Queue holds 2 entries; assert Req together with push and pop -> next cycle count=0, D_valid=0, D_PC=32'h4180; a push the following cycle of 4180 appears with D_valid=1.
- Queue holds 3000/3004; flush with pop=1 -> count=0, D_PC=3000; Req and flush together -> D_PC=32'h4180.
